mouse_cursor_unit: RTL

MOUSE_CURSOR_UNIT -- requirements
Module: mouse_cursor_unit

---
 rtl/mouse_cursor_pkg.sv | 33 +++
 rtl/evt_fifo.sv | 67 ++++++
 rtl/mouse_cursor_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mouse_cursor_pkg.sv
// Shared defaults, event payload layout and coordinate clamp helper for the
// mouse cursor unit.
package mouse_cursor_pkg;

   localparam int unsigned DEF_DELTA_W    = 8;
   localparam int unsigned DEF_XW         = 10;
   localparam int unsigned DEF_YW         = 10;
   localparam int unsigned DEF_SCREEN_W   = 640;
   localparam int unsigned DEF_SCREEN_H   = 480;
   localparam int unsigned DEF_NBTN       = 3;
   localparam int unsigned DEF_FIFO_DEPTH = 8;
   localparam int unsigned DEF_IW         = (DEF_NBTN > 1) ? $clog2(DEF_NBTN) : 1;

   // Event payload at the default geometry: {button index, press, x, y}
   typedef struct packed {
      logic [DEF_IW-1:0] idx;
      logic              press;
      logic [DEF_XW-1:0] x;
      logic [DEF_YW-1:0] y;
   } mouse_evt_t;

   // Clamp a signed coordinate sum into [0, limit-1]
   function automatic int unsigned clamp_coord(input int signed v, input int unsigned limit);
      if (v < 0) begin
         return 0;
      end
      if (v > int'(limit) - 1) begin
         return limit - 1;
      end
      return $unsigned(v);
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead event queue.
// Ports: clk/rst_n; push/push_data write side; pop read side (ignored when
// empty); head_data is the oldest entry (0 when empty); full/empty are
// registered flags; drop_c flags a push rejected because the queue is full
// and no pop frees a slot this cycle.
module evt_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty,
   output logic         drop_c
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] mem [DEPTH];
   // One extra pointer bit tells full from empty when the indices match
   logic [AW:0]  wr_ptr, rd_ptr, wr_next, rd_next;
   logic         pop_ok, push_ok;

   // A full queue still accepts a push when the head leaves in the same cycle
   always_comb begin
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      drop_c  = push & full & ~pop_ok;
      wr_next = wr_ptr;
      rd_next = rd_ptr;
      if (push_ok) begin
         wr_next = wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
         rd_next = rd_ptr + (AW+1)'(1);
      end
   end

   // Pointers and occupancy flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         empty  <= (wr_next == rd_next);
         full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      end
   end

   // Storage
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mouse_cursor_unit.sv
// Mouse cursor tracker: integrates signed relative deltas into a clamped
// absolute position, synchronises raw buttons, and queues press/release
// events stamped with the cursor position.
// Ports: clk_clk, reset_reset_n (async active-low); delta_valid/delta_x/
// delta_y motion input (+y down); buttons raw levels; cursor_x/cursor_y
// position; btn_level synchronised buttons; evt_valid/evt_ready/evt_data
// event stream {idx, press, x, y}; evt_overflow sticky drop flag cleared by
// clr_overflow.
module mouse_cursor_unit
   import mouse_cursor_pkg::*;
#(
   parameter int unsigned DELTA_W    = DEF_DELTA_W,
   parameter int unsigned XW         = DEF_XW,
   parameter int unsigned YW         = DEF_YW,
   parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
   parameter int unsigned NBTN       = DEF_NBTN,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int unsigned IW        = (NBTN > 1) ? $clog2(NBTN) : 1,
   localparam int unsigned EW        = IW + 1 + XW + YW
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic                      delta_valid,
   input  logic signed [DELTA_W-1:0] delta_x,
   input  logic signed [DELTA_W-1:0] delta_y,
   input  logic [NBTN-1:0]           buttons,
   output logic [XW-1:0]             cursor_x,
   output logic [YW-1:0]             cursor_y,
   output logic [NBTN-1:0]           btn_level,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [EW-1:0]             evt_data,
   output logic                      evt_overflow,
   input  logic                      clr_overflow
);

   localparam int unsigned SWX = ((XW > DELTA_W) ? XW : DELTA_W) + 2;
   localparam int unsigned SWY = ((YW > DELTA_W) ? YW : DELTA_W) + 2;

   logic signed [SWX-1:0] sum_x;
   logic signed [SWY-1:0] sum_y;
   logic [XW-1:0]         next_x;
   logic [YW-1:0]         next_y;

   logic [NBTN-1:0]       sync1, sync2, sync3;
   logic [NBTN-1:0]       edges, pending, cand, sel_onehot, pending_next;
   logic [IW-1:0]         sel_idx;
   logic                  sel_level;
   logic                  push_evt;
   logic                  merge;
   logic                  fifo_full, fifo_empty, fifo_drop_c;

   // Cursor integration: widen both operands so the sum cannot wrap
   always_comb begin
      sum_x  = $signed(SWX'(cursor_x)) + SWX'(delta_x);
      sum_y  = $signed(SWY'(cursor_y)) + SWY'(delta_y);
      next_x = XW'(clamp_coord(int'(sum_x), SCREEN_W));
      next_y = YW'(clamp_coord(int'(sum_y), SCREEN_H));
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cursor_x <= XW'(SCREEN_W / 2);
         cursor_y <= YW'(SCREEN_H / 2);
      end else if (delta_valid) begin
         cursor_x <= next_x;
         cursor_y <= next_y;
      end
   end

   // Button synchroniser plus one delayed copy for edge detection
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= buttons;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign btn_level = sync2;
   assign edges     = sync2 ^ sync3;

   // Serialise edges: the lowest candidate bit becomes this cycle's event
   always_comb begin
      cand       = pending | edges;
      merge      = |(pending & edges);
      sel_idx    = '0;
      sel_level  = 1'b0;
      sel_onehot = '0;
      push_evt   = 1'b0;
      for (int i = int'(NBTN) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_idx       = IW'(i);
            sel_level     = sync2[i];
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            push_evt      = 1'b1;
         end
      end
      pending_next = cand & ~sel_onehot;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Sticky overflow; a new drop or merge beats a clear in the same cycle
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         evt_overflow <= 1'b0;
      end else if (merge || fifo_drop_c) begin
         evt_overflow <= 1'b1;
      end else if (clr_overflow) begin
         evt_overflow <= 1'b0;
      end
   end

   evt_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (push_evt),
      .push_data ({sel_idx, sel_level, cursor_x, cursor_y}),
      .pop       (evt_ready),
      .head_data (evt_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop_c    (fifo_drop_c)
   );

   assign evt_valid = ~fifo_empty;

   // Full flag is informational here; drops are reported via drop_c
   logic unused_full;
   assign unused_full = fifo_full;

endmodule
